// File: rtl/sistema_factorial_if.sv
// Request/response bundle between a controller and the factorial engine.
// The controller raises inicio with n valid and holds it until fin is seen.
// It then drops inicio, and the engine returns to idle.
interface sistema_factorial_if #(
  parameter int N_W   = 3,
  parameter int OUT_W = 13
);
  logic             inicio;
  logic [N_W-1:0]   n;
  logic [OUT_W-1:0] salida;
  logic             fin;

  // Controller side: drives the request and operand, observes the result.
  modport master (
    output inicio,
    output n,
    input  salida,
    input  fin
  );

  // Engine side: observes the request and operand, drives the result.
  modport slave (
    input  inicio,
    input  n,
    output salida,
    output fin
  );
endinterface

// File: rtl/sistema_factorial.sv
// Iterative factorial engine for a 3-bit operand.
// acc starts at 1 and is multiplied by a down-counter k until k <= 1.
// Each multiply is a 3-cycle shift-add over the bits of k.
// The result and done flag are registered and follow a 4-phase inicio/fin handshake.
module sistema_factorial #(
  parameter int N_W   = 3,
  parameter int OUT_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  sistema_factorial_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MUL    = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [N_W-1:0]   k;
  logic [OUT_W-1:0] partial;
  logic [1:0]       bitcnt;
  logic [OUT_W-1:0] out_value;
  logic             done_flag;
  logic             k_bit;

  // One shift-add step: add acc shifted by the bit position when that bit of k is set.
  // The sum is truncated to OUT_W bits. Products never exceed 7! = 5040, so no overflow occurs.
  function automatic logic [OUT_W-1:0] mul_step(
    input logic [OUT_W-1:0] part_in,
    input logic [OUT_W-1:0] acc_in,
    input logic             bit_set,
    input logic [1:0]       shift
  );
    logic [OUT_W-1:0] shifted;
    shifted = acc_in << shift;
    if (bit_set) begin
      mul_step = part_in + shifted;
    end else begin
      mul_step = part_in;
    end
  endfunction

  // Select the multiplier bit of k for the current shift-add cycle.
  always_comb begin
    k_bit = 1'b0;
    case (bitcnt)
      2'd0:    k_bit = k[0];
      2'd1:    k_bit = k[1];
      2'd2:    k_bit = k[2];
      default: k_bit = 1'b0;
    endcase
  end

  // Control FSM and datapath registers.
  // salida changes only when DONE is entered. fin is high for every cycle spent in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= OUT_W'(1);
      k         <= '0;
      partial   <= '0;
      bitcnt    <= 2'd0;
      out_value <= '0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_flag <= 1'b0;
          if (bus.inicio) begin
            k     <= bus.n;
            acc   <= OUT_W'(1);
            state <= CHECK;
          end else begin
            state <= IDLE;
          end
        end

        CHECK: begin
          if (k <= N_W'(1)) begin
            out_value <= acc;
            done_flag <= 1'b1;
            state     <= DONE;
          end else begin
            partial <= '0;
            bitcnt  <= 2'd0;
            state   <= MUL;
          end
        end

        MUL: begin
          partial <= mul_step(partial, acc, k_bit, bitcnt);
          if (bitcnt == 2'd2) begin
            bitcnt <= 2'd0;
            state  <= UPDATE;
          end else begin
            bitcnt <= bitcnt + 2'd1;
            state  <= MUL;
          end
        end

        UPDATE: begin
          acc   <= partial;
          k     <= k - N_W'(1);
          state <= CHECK;
        end

        DONE: begin
          // Holding inicio keeps the result on display; a restart needs a pass through IDLE.
          if (!bus.inicio) begin
            done_flag <= 1'b0;
            state     <= IDLE;
          end else begin
            done_flag <= 1'b1;
            state     <= DONE;
          end
        end

        default: begin
          done_flag <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.salida = out_value;
  assign bus.fin    = done_flag;

endmodule

// File: tb/tb_sistema_factorial.sv
// Self-checking bench for sistema_factorial.
// Each start pushes the expected result and latency to a scoreboard queue.
// Both are popped and compared when fin is observed.
module tb_sistema_factorial;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sistema_factorial_if #(.N_W(3), .OUT_W(13)) bus ();

  sistema_factorial #(.N_W(3), .OUT_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int res;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check_value(input string tag, input int obs, input int exp_v);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int fact(input int v);
    int r;
    r = 1;
    for (int i = 2; i <= v; i++) r = r * i;
    return r;
  endfunction

  function automatic int latency(input int v);
    if (v <= 1) return 2;
    return 2 + 5 * (v - 1);
  endfunction

  // Raise inicio with operand v and record what the engine owes us.
  task automatic start(input int v);
    exp_t e;
    @(negedge clk);
    bus.n      = 3'(v);
    bus.inicio = 1'b1;
    e.res = fact(v);
    e.lat = latency(v);
    sb.push_back(e);
  endtask

  // Count edges from the sampling edge (edge 1) until fin is seen; then check against the scoreboard.
  task automatic wait_fin(input string tag);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.fin === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      check_value({tag, "_timeout"}, cyc, e.lat);
    end else begin
      check_value({tag, "_latency"}, cyc, e.lat);
      check_value({tag, "_salida"}, int'(bus.salida), e.res);
    end
  endtask

  // Full handshake: hold inicio for extra cycles past fin, then drop it and check the return to idle.
  task automatic do_op(input int v, input int extra, input string tag);
    int res;
    res = fact(v);
    start(v);
    wait_fin(tag);
    for (int i = 0; i < extra; i++) begin
      @(posedge clk);
      #1;
      check_value({tag, "_hold_fin"}, int'(bus.fin), 1);
    end
    check_value({tag, "_hold_salida"}, int'(bus.salida), res);
    @(negedge clk);
    bus.inicio = 1'b0;
    @(posedge clk);
    #1;
    check_value({tag, "_drop_fin"}, int'(bus.fin), 0);
    check_value({tag, "_drop_salida"}, int'(bus.salida), res);
  endtask

  initial begin
    bus.inicio = 1'b0;
    bus.n      = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_fin", int'(bus.fin), 0);
    check_value("rst_salida", int'(bus.salida), 0);
    @(negedge clk);
    rst = 1'b1;

    // First op n=0 plus full sweep 0..7
    do_op(0, 0, "first_n0");
    for (int v = 0; v < 8; v++) begin
      do_op(v, 2, $sformatf("sweep_n%0d", v));
    end

    // Holding inicio 10 cycles past fin must not restart
    do_op(5, 10, "hold_n5");

    // n changed mid-computation is ignored
    start(6);
    fork
      begin
        repeat (3) @(negedge clk);
        bus.n = 3'd3;
      end
    join_none
    wait_fin("nchg_n6");
    @(negedge clk);
    bus.inicio = 1'b0;
    @(posedge clk);
    #1;
    check_value("nchg_drop_fin", int'(bus.fin), 0);

    // Reset mid-computation aborts immediately
    start(7);
    repeat (10) @(posedge clk);
    #2;
    rst        = 1'b0;
    bus.inicio = 1'b0;
    #1;
    check_value("abort_fin", int'(bus.fin), 0);
    check_value("abort_salida", int'(bus.salida), 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b1;
    do_op(4, 1, "after_abort_n4");

    // inicio dropped mid-computation: finishes, fin high one cycle, then idle
    start(3);
    fork
      begin
        repeat (2) @(negedge clk);
        bus.inicio = 1'b0;
      end
    join_none
    wait_fin("early_drop_n3");
    @(posedge clk);
    #1;
    check_value("early_drop_fin_low", int'(bus.fin), 0);
    check_value("early_drop_salida", int'(bus.salida), 6);
    repeat (3) @(posedge clk);
    #1;
    check_value("early_drop_idle_fin", int'(bus.fin), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
